control_juego: RTL and testbench

CONTROL_JUEGO -- requirements
Module: control_juego

---
 rtl/control_juego.sv | 177 +++++++++++++++++
 tb/tb_control_juego.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/control_juego.sv
// control_juego: guess-the-number game controller.
// An 8-bit LFSR picks a 2-bit hidden target on every entry to ESPERA. The player
// guesses with boton/intento, and each result is shown on numero for T_MOSTRAR
// cycles. ACIERTOS_FIN consecutive hits end the game, shown as numero=3.
// Optional guess timeout: define CONTROL_JUEGO_TIMEOUT_EN.
module control_juego #(
   parameter int unsigned T_MOSTRAR    = 50000000,
   parameter int unsigned ACIERTOS_FIN = 3,
   parameter int unsigned T_ESPERA     = 250000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inicio,
   input  logic       boton,
   input  logic [1:0] intento,
   output logic [1:0] numero,
   output logic [3:0] aciertos,
   output logic [1:0] estado,
   output logic [1:0] objetivo
);

   localparam int unsigned LFSR_W = 8;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned ACI_W  = 4;
   localparam int unsigned NUM_W  = 2;

   localparam logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5;
   localparam logic [CNT_W-1:0]  MOSTRAR_FIN = CNT_W'(T_MOSTRAR - 1);
   localparam logic [ACI_W-1:0]  ACI_FIN     = ACI_W'(ACIERTOS_FIN);

   localparam logic [NUM_W-1:0] NUM_NADA    = 2'd0;
   localparam logic [NUM_W-1:0] NUM_FALLO   = 2'd1;
   localparam logic [NUM_W-1:0] NUM_ACIERTO = 2'd2;
   localparam logic [NUM_W-1:0] NUM_FIN     = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ESPERA  = 2'd1,
      MOSTRAR = 2'd2,
      FIN     = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [NUM_W-1:0]  numero_q, numero_d;
   logic [ACI_W-1:0]  aciertos_q, aciertos_d;
   logic [1:0]        objetivo_q, objetivo_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_c;
   logic              lfsr_fb_c;
   logic [ACI_W-1:0]  aciertos_inc_c;

   // Feedback taps for x^8+x^6+x^5+x^4+1
   assign lfsr_fb_c      = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign aciertos_inc_c = aciertos_q + ACI_W'(1);

`ifdef CONTROL_JUEGO_TIMEOUT_EN
   localparam logic [CNT_W-1:0] ESPERA_FIN = CNT_W'(T_ESPERA - 1);

   logic [CNT_W-1:0] wcnt_q, wcnt_d;

   // A timeout is reported in the cycle that completes T_ESPERA cycles in ESPERA
   assign timeout_c = (state_q == ESPERA) && (wcnt_q == ESPERA_FIN);

   // Wait counter: cleared on ESPERA entry, counts (saturating) while in ESPERA
   always_comb begin
      wcnt_d = wcnt_q;
      if ((state_d == ESPERA) && (state_q != ESPERA)) begin
         wcnt_d = '0;
      end else if ((state_q == ESPERA) && (wcnt_q != ESPERA_FIN)) begin
         wcnt_d = wcnt_q + CNT_W'(1);
      end
   end

   // Wait counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Parameter legality
   assert property (@(posedge clk) disable iff (!rst_n)
      (T_MOSTRAR != 0) && (ACIERTOS_FIN >= 1) && (ACIERTOS_FIN <= 15) && (T_ESPERA != 0));

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      numero_d   = numero_q;
      aciertos_d = aciertos_q;
      objetivo_d = objetivo_q;
      cnt_d      = cnt_q;
      lfsr_d     = {lfsr_q[LFSR_W-2:0], lfsr_fb_c};

      case (state_q)
         IDLE: begin
            numero_d = NUM_NADA;
            if (inicio) begin
               state_d    = ESPERA;
               aciertos_d = '0;
               objetivo_d = lfsr_q[1:0];
            end
         end
         ESPERA: begin
            numero_d = NUM_NADA;
            if (boton && (intento == objetivo_q)) begin
               aciertos_d = aciertos_inc_c;
               if (aciertos_inc_c == ACI_FIN) begin
                  state_d  = FIN;
                  numero_d = NUM_FIN;
               end else begin
                  state_d  = MOSTRAR;
                  numero_d = NUM_ACIERTO;
                  cnt_d    = '0;
               end
            end else if (boton || timeout_c) begin
               state_d    = MOSTRAR;
               numero_d   = NUM_FALLO;
               aciertos_d = '0;
               cnt_d      = '0;
            end
         end
         MOSTRAR: begin
            if (cnt_q == MOSTRAR_FIN) begin
               state_d    = ESPERA;
               numero_d   = NUM_NADA;
               objetivo_d = lfsr_q[1:0];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIN: begin
            numero_d = NUM_FIN;
            if (inicio) begin
               state_d    = ESPERA;
               numero_d   = NUM_NADA;
               aciertos_d = '0;
               objetivo_d = lfsr_q[1:0];
            end
         end
         default: begin
            state_d  = IDLE;
            numero_d = NUM_NADA;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         numero_q   <= NUM_NADA;
         aciertos_q <= '0;
         objetivo_q <= '0;
         lfsr_q     <= LFSR_SEED;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         numero_q   <= numero_d;
         aciertos_q <= aciertos_d;
         objetivo_q <= objetivo_d;
         lfsr_q     <= lfsr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign numero   = numero_q;
   assign aciertos = aciertos_q;
   assign estado   = state_q;
   assign objetivo = objetivo_q;

endmodule

// File: tb/tb_control_juego.sv
// tb_control_juego: scoreboard bench for control_juego (T_MOSTRAR=4,
// ACIERTOS_FIN=3, T_ESPERA=10). The driver pushes the expected outputs for each
// clock edge, and the monitor pops and compares them shortly after that edge.
module tb_control_juego;

   localparam int unsigned T_MOSTRAR    = 4;
   localparam int unsigned ACIERTOS_FIN = 3;
   localparam int unsigned T_ESPERA     = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inicio = 1'b0;
   logic       boton = 1'b0;
   logic [1:0] intento = 2'd0;
   logic [1:0] numero;
   logic [3:0] aciertos;
   logic [1:0] estado;
   logic [1:0] objetivo;

   typedef struct {
      string      name;
      logic [1:0] est;
      logic [1:0] num;
      logic [3:0] ac;
      logic [1:0] obj;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [7:0] m_lfsr;

   control_juego #(
      .T_MOSTRAR   (T_MOSTRAR),
      .ACIERTOS_FIN(ACIERTOS_FIN),
      .T_ESPERA    (T_ESPERA)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inicio  (inicio),
      .boton   (boton),
      .intento (intento),
      .numero  (numero),
      .aciertos(aciertos),
      .estado  (estado),
      .objetivo(objetivo)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr = 8'hA5;
      else        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic check(input exp_t e);
      n_tests++;
      if (estado !== e.est || numero !== e.num || aciertos !== e.ac || objetivo !== e.obj) begin
         n_fail++;
         $display("FAIL %s: got estado=%0d numero=%0d aciertos=%0d objetivo=%0d, required estado=%0d numero=%0d aciertos=%0d objetivo=%0d",
                  e.name, estado, numero, aciertos, objetivo, e.est, e.num, e.ac, e.obj);
      end
   endtask

   // Called at a negedge: drive inputs for the next edge, push its expected result
   task automatic step(input string nm, input logic ini, input logic bot, input logic [1:0] it,
                       input logic [1:0] e_est, input logic [1:0] e_num,
                       input logic [3:0] e_ac, input logic [1:0] e_obj);
      exp_t e;
      inicio  = ini;
      boton   = bot;
      intento = it;
      e = '{name: nm, est: e_est, num: e_num, ac: e_ac, obj: e_obj};
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Correct guess from ESPERA (not the last one), hold with stray strobes, back to ESPERA
   task automatic acierto(input string nm, input logic [3:0] ac, inout logic [1:0] tgt);
      step(nm, 1'b0, 1'b1, tgt, 2'd2, 2'd2, ac, tgt);
      for (int i = 0; i < 3; i++)
         step({nm, "_hold"}, (i == 2), (i == 1), ~tgt, 2'd2, 2'd2, ac, tgt);
      tgt = m_lfsr[1:0];
      step({nm, "_vuelta"}, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, ac, tgt);
   endtask

   // Monitor: compare each pushed expectation just after its clock edge
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) check(sb.pop_front());
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] tgt;
      exp_t       e;

      #3;
      e = '{name: "reset", est: 2'd0, num: 2'd0, ac: 4'd0, obj: 2'd0};
      check(e);
      @(negedge clk);
      rst_n = 1'b1;

      step("idle_boton", 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd0, 2'd0);
      tgt = m_lfsr[1:0];
      step("inicio", 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, tgt);
      acierto("acierto1", 4'd1, tgt);
      acierto("acierto2", 4'd2, tgt);
      step("fin", 1'b0, 1'b1, tgt, 2'd3, 2'd3, 4'd3, tgt);
      step("fin_boton", 1'b0, 1'b1, ~tgt, 2'd3, 2'd3, 4'd3, tgt);
      step("fin_quieto", 1'b0, 1'b0, 2'd0, 2'd3, 2'd3, 4'd3, tgt);
      tgt = m_lfsr[1:0];
      step("fin_inicio_boton", 1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 4'd0, tgt);

      acierto("r2_acierto1", 4'd1, tgt);
      acierto("r2_acierto2", 4'd2, tgt);
      step("fallo", 1'b0, 1'b1, tgt ^ 2'd1, 2'd2, 2'd1, 4'd0, tgt);
      for (int i = 0; i < 3; i++)
         step("fallo_hold", 1'b0, 1'b1, tgt, 2'd2, 2'd1, 4'd0, tgt);
      tgt = m_lfsr[1:0];
      step("fallo_vuelta", 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, tgt);

      step("espera_inicio_boton", 1'b1, 1'b1, tgt, 2'd2, 2'd2, 4'd1, tgt);
      step("antes_reset", 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 4'd1, tgt);

      // Asynchronous reset mid-MOSTRAR, away from any clock edge
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      e = '{name: "reset_mostrar", est: 2'd0, num: 2'd0, ac: 4'd0, obj: 2'd0};
      check(e);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      tgt = m_lfsr[1:0];
      step("inicio2", 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, tgt);
`ifdef CONTROL_JUEGO_TIMEOUT_EN
      for (int i = 0; i < 9; i++)
         step("espera_quieto", 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, tgt);
      step("timeout", 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 4'd0, tgt);
      for (int i = 0; i < 3; i++)
         step("timeout_hold", 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 4'd0, tgt);
      tgt = m_lfsr[1:0];
      step("timeout_vuelta", 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, tgt);
`else
      for (int i = 0; i < 100; i++)
         step("espera_sin_timeout", 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 4'd0, tgt);
`endif

      inicio = 1'b0;
      boton  = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
